// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types and constants for the sequential restoring divider.
//             - div_state_t : controller state encoding (IDLE / RUN / DONE)
//             - DIV_GROUP   : width of one carry-lookahead group in the
//                             subtractor
//  Revision : 1.0  initial release
// ============================================================================
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_GROUP = 4;

endpackage : div_pkg
`default_nettype wire

// File: rtl/cla_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : cla_subtractor
//  Purpose  : N-bit unsigned subtractor diff = a - b, built as a + ~b + 1 on
//             4-bit carry-lookahead groups chained group to group.
//  Ports    : a      in  N  minuend
//             b      in  N  subtrahend
//             diff   out N  a - b (modulo 2^N)
//             borrow out 1  1 when a < b (inverse of the final carry)
//  Revision : 1.0  initial release
// ============================================================================
module cla_subtractor
   import div_pkg::*;
#(
   parameter int N = 17
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   // Operands are zero-extended up to a whole number of groups. In the pad
   // region a=0 and ~b=1, so every pad bit simply propagates the carry and
   // the final carry still means "a >= b".
   localparam int NG = (N + DIV_GROUP - 1) / DIV_GROUP;
   localparam int NP = NG * DIV_GROUP;

   logic [NP-1:0] w_a;
   logic [NP-1:0] w_b_n;
   logic [NP-1:0] w_gen;
   logic [NP-1:0] w_prop;
   logic [NP-1:0] w_sum;
   logic [NG:0]   w_group_c;

   assign w_a          = NP'(a);
   assign w_b_n        = ~(NP'(b));
   assign w_gen        = w_a & w_b_n;
   assign w_prop       = w_a ^ w_b_n;
   assign w_group_c[0] = 1'b1;            // +1 completes the two's complement

   generate
      for (genvar gi = 0; gi < NG; gi++) begin : g_group
         logic [3:0] w_g;
         logic [3:0] w_p;
         logic [4:0] w_c;

         assign w_g    = w_gen [gi*DIV_GROUP +: DIV_GROUP];
         assign w_p    = w_prop[gi*DIV_GROUP +: DIV_GROUP];
         assign w_c[0] = w_group_c[gi];
         assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
         assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
         assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                       | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
         assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                       | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                       | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

         assign w_sum[gi*DIV_GROUP +: DIV_GROUP] = w_p ^ w_c[3:0];
         assign w_group_c[gi+1]                  = w_c[4];
      end

      if (NP > N) begin : g_pad
         // Pad-region sum bits carry no information.
         logic w_unused_pad;
         assign w_unused_pad = ^w_sum[NP-1:N];
      end
   endgenerate

   assign diff   = w_sum[N-1:0];
   assign borrow = ~w_group_c[NG];

endmodule : cla_subtractor
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider
//  Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per
//             clock (MSB first), valid/ready handshake on both sides.
//  Config   : DIV_REMAINDER_EN - when defined, the remainder port exists.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready     operand handshake (dividend, divisor)
//             out_valid/out_ready   result handshake (quotient, remainder,
//                                   div_by_zero)
//  Revision : 1.0  initial release
// ============================================================================
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 16   // multiple of 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
`ifdef DIV_REMAINDER_EN
   output logic [WIDTH-1:0] remainder,
`endif
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_t       r_state;
   div_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_step;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_dividend;   // shifts left; MSB feeds the next step
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH:0]   r_part;       // partial remainder R
   logic             r_dbz;
   logic [WIDTH:0]   w_shifted;
   logic [WIDTH:0]   w_trial;
   logic             w_borrow;
   logic             w_accept;
   logic             w_last_step;
   logic             w_unused_part_msb;

   assign w_shifted         = {r_part[WIDTH-1:0], r_dividend[WIDTH-1]};
   assign w_last_step       = (r_step == CNT_W'(WIDTH - 1));
   assign w_accept          = in_valid && in_ready;
   // R < divisor after every step, so its MSB is never needed for the shift.
   assign w_unused_part_msb = r_part[WIDTH];

   cla_subtractor #(
      .N      (WIDTH + 1)
   ) u_sub (
      .a      (w_shifted),
      .b      ({1'b0, r_divisor}),
      .diff   (w_trial),
      .borrow (w_borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = (divisor == '0) ? DONE : RUN;
         end
         RUN: begin
            if (w_last_step) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step     <= '0;
         r_divisor  <= '0;
         r_dividend <= '0;
         r_quot     <= '0;
         r_part     <= '0;
         r_dbz      <= 1'b0;
      end else if (w_accept) begin
         r_divisor  <= divisor;
         r_dividend <= dividend;
         r_step     <= '0;
         r_dbz      <= (divisor == '0);
         if (divisor == '0) begin
            // Result is final right away: all-ones quotient, R = dividend.
            r_quot <= '1;
            r_part <= {1'b0, dividend};
         end else begin
            r_quot <= '0;
            r_part <= '0;
         end
      end else if (r_state == RUN) begin
         r_step     <= r_step + CNT_W'(1);
         r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
         if (w_borrow) begin
            r_part <= w_shifted;
            r_quot <= {r_quot[WIDTH-2:0], 1'b0};
         end else begin
            r_part <= w_trial;
            r_quot <= {r_quot[WIDTH-2:0], 1'b1};
         end
      end
   end

   assign quotient    = r_quot;
   assign div_by_zero = r_dbz;
`ifdef DIV_REMAINDER_EN
   assign remainder   = r_part[WIDTH-1:0];
`endif

endmodule : seq_restoring_divider
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_restoring_divider
//  Purpose  : Self-checking bench for seq_restoring_divider (WIDTH=16).
//             Expected results come from plain / and % arithmetic.
//             Remainder checks are active when DIV_REMAINDER_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_restoring_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] rem_w;
   logic         div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
`ifdef DIV_REMAINDER_EN
      .remainder   (rem_w),
`endif
      .div_by_zero (div_by_zero)
   );
`ifndef DIV_REMAINDER_EN
   assign rem_w = '0;
`endif

   // Reference model: plain integer division with the divide-by-zero rule.
   function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? {W{1'b1}} : a / b;
   endfunction
   function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? a : a % b;
   endfunction
   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 16'd1;
         2:       return '1;
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   // Drives one operation and waits for its result (not consumed).
   // lat counts edges from the accepting edge (inclusive) to out_valid.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output int lat, output bit to);
      bit acc = 0;
      bit acc_now;
      int guard = 0;
      in_valid = 1'b1; dividend = a; divisor = b;
      while (!acc && guard < 64) begin
         acc_now = in_ready;
         @(posedge clk); #1;
         guard++;
         if (acc_now) acc = 1;
      end
      in_valid = 1'b0;
      lat = 1;
      while (acc && !out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      to  = !acc || !out_valid;
      q   = quotient;
      r   = rem_w;
      dbz = div_by_zero;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: in_ready=%b out_valid=%b q=%h dbz=%b, expected 1 0 0000 0",
                  in_ready, out_valid, quotient, div_by_zero);
      end
`ifdef DIV_REMAINDER_EN
      n_tests++;
      if (rem_w !== '0) begin
         n_fail++;
         $display("FAIL reset_rem: got %h expected 0000", rem_w);
      end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [W-1:0] ta [5] = '{16'd100, 16'hFFFF, 16'd3, 16'd0, 16'd65535};
      logic [W-1:0] tb [5] = '{16'd7, 16'd1, 16'd10, 16'd5, 16'd65535};
      logic [W-1:0] q, r;
      logic dbz;
      int lat;
      bit to;
      for (int i = 0; i < 5; i++) begin
         run_op(ta[i], tb[i], q, r, dbz, lat, to);
         n_tests++;
         if (to || lat != W + 1 || q !== ref_q(ta[i], tb[i]) || dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL basic %0d/%0d: q=%h lat=%0d dbz=%b to=%b, expected q=%h lat=%0d dbz=0",
                     ta[i], tb[i], q, lat, dbz, to, ref_q(ta[i], tb[i]), W + 1);
         end
`ifdef DIV_REMAINDER_EN
         n_tests++;
         if (r !== ref_r(ta[i], tb[i])) begin
            n_fail++;
            $display("FAIL basic_rem %0d/%0d: got %h expected %h", ta[i], tb[i], r, ref_r(ta[i], tb[i]));
         end
`endif
         consume();
      end
   endtask

   task automatic test_div_by_zero();
      logic [W-1:0] q, r;
      logic dbz;
      int lat;
      bit to;
      int guard;
      run_op(16'd5, 16'd0, q, r, dbz, lat, to);
      n_tests++;
      if (to || lat != 1 || q !== 16'hFFFF || dbz !== 1'b1) begin
         n_fail++;
         $display("FAIL div0: q=%h lat=%0d dbz=%b to=%b, expected q=ffff lat=1 dbz=1", q, lat, dbz, to);
      end
`ifdef DIV_REMAINDER_EN
      n_tests++;
      if (r !== 16'd5) begin
         n_fail++;
         $display("FAIL div0_rem: got %h expected 0005", r);
      end
`endif
      consume();
      // The flag must drop as soon as the next operation is accepted.
      in_valid = 1'b1; dividend = 16'd20; divisor = 16'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++;
      if (div_by_zero !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL div0_clear: dbz=%b in_ready=%b, expected 0 0", div_by_zero, in_ready);
      end
      guard = 0;
      while (!out_valid && guard < 64) begin @(posedge clk); #1; guard++; end
      n_tests++;
      if (!out_valid || quotient !== 16'd5) begin
         n_fail++;
         $display("FAIL div0_next: out_valid=%b q=%h, expected 1 0005", out_valid, quotient);
      end
      consume();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] q, r;
      logic dbz;
      int lat;
      bit to;
      run_op(16'd1000, 16'd33, q, r, dbz, lat, to);
      in_valid = 1'b1; dividend = 16'd77; divisor = 16'd2;   // must be ignored
      for (int c = 0; c < 5; c++) begin
         n_tests++;
         if (to || !out_valid || in_ready !== 1'b0 || quotient !== 16'd30 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure c%0d: ov=%b ir=%b q=%h, expected 1 0 001e", c, out_valid, in_ready, quotient);
         end
`ifdef DIV_REMAINDER_EN
         n_tests++;
         if (rem_w !== 16'd10) begin
            n_fail++;
            $display("FAIL backpressure_rem c%0d: got %h expected 000a", c, rem_w);
         end
`endif
         @(posedge clk); #1;
      end
      // Handoff edge: in_valid still high, but no accept may happen here.
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL handoff: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_midrun();
      logic [W-1:0] q, r;
      logic dbz;
      int lat;
      bit to;
      in_valid = 1'b1; dividend = 16'd40000; divisor = 16'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 || div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset: ov=%b ir=%b q=%h dbz=%b, expected 0 1 0000 0",
                  out_valid, in_ready, quotient, div_by_zero);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(16'd9, 16'd2, q, r, dbz, lat, to);
      n_tests++;
      if (to || q !== 16'd4 || lat != W + 1) begin
         n_fail++;
         $display("FAIL after_reset 9/2: q=%h lat=%0d to=%b, expected 0004 lat=%0d", q, lat, to, W + 1);
      end
`ifdef DIV_REMAINDER_EN
      n_tests++;
      if (r !== 16'd1) begin
         n_fail++;
         $display("FAIL after_reset_rem: got %h expected 0001", r);
      end
`endif
      consume();
   endtask

   task automatic test_operand_hold();
      int guard = 0;
      in_valid = 1'b1; dividend = 16'd200; divisor = 16'd9;
      @(posedge clk); #1;
      dividend = 16'd7; divisor = 16'd0;   // changes after accept have no effect
      while (!out_valid && guard < 64) begin @(posedge clk); #1; guard++; end
      in_valid = 1'b0;
      n_tests++;
      if (!out_valid || quotient !== 16'd22 || div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL operand_hold: ov=%b q=%h dbz=%b, expected 1 0016 0", out_valid, quotient, div_by_zero);
      end
`ifdef DIV_REMAINDER_EN
      n_tests++;
      if (rem_w !== 16'd2) begin
         n_fail++;
         $display("FAIL operand_hold_rem: got %h expected 0002", rem_w);
      end
`endif
      consume();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] q, r;
      logic [W-1:0] a, b;
      logic dbz;
      int lat;
      bit to;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = W'($urandom);
         b = W'($urandom_range(1, 300));
         run_op(a, b, q, r, dbz, lat, to);
         n_tests++;
         if (to || lat != W + 1 || q !== ref_q(a, b) || r !== ((W'(0)) | rem_w)) begin
            n_fail++;
            $display("FAIL back_to_back %0d/%0d: q=%h lat=%0d to=%b, expected q=%h lat=%0d",
                     a, b, q, lat, to, ref_q(a, b), W + 1);
         end
`ifdef DIV_REMAINDER_EN
         n_tests++;
         if (r !== ref_r(a, b)) begin
            n_fail++;
            $display("FAIL back_to_back_rem %0d/%0d: got %h expected %h", a, b, r, ref_r(a, b));
         end
`endif
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, eq, er;
      bit done, checked, w;
      int cyc, guard;
      bit acc, acc_now;
      for (int i = 0; i < 1500; i++) begin
         a = pick_operand();
         b = pick_operand();
         eq = ref_q(a, b);
         er = ref_r(a, b);
         in_valid = 1'b1; dividend = a; divisor = b;
         acc = 0; guard = 0;
         while (!acc && guard < 64) begin
            acc_now = in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc_now) acc = 1;
         end
         done = 0; checked = 0; cyc = 0;
         while (acc && !done && cyc < 200) begin
            if (out_valid && !checked) begin
               checked = 1;
               n_tests++;
               if (quotient !== eq || div_by_zero !== (b == 0)
`ifdef DIV_REMAINDER_EN
                   || rem_w !== er
`endif
                  ) begin
                  n_fail++;
                  $display("FAIL random %0d/%0d: q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                           a, b, quotient, rem_w, div_by_zero, eq, er, (b == 0));
               end
            end
            // Busy-time noise on the input side must be ignored.
            in_valid  = 1'($urandom_range(0, 1));
            dividend  = W'($urandom);
            divisor   = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            w = out_valid && out_ready;
            @(posedge clk); #1;
            cyc++;
            if (w) done = 1;
         end
         in_valid  = 1'b0;
         out_ready = 1'b0;
         if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL random_timeout %0d/%0d: acc=%b done=%b", a, b, acc, done);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_div_by_zero();
      test_backpressure();
      test_reset_midrun();
      test_operand_hold();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_seq_restoring_divider
`default_nettype wire
